// File: rtl/id_issue_stage_pkg.sv
// Shared constants, opcode encoding and ID/EX bundle for the decode/issue stage.
// Imported by id_issue_stage and reg_file_8x16.
package id_issue_stage_pkg;

    localparam int WORD_LEN    = 16;
    localparam int NREGS       = 8;
    localparam int REG_IDX_W   = 3;
    localparam int EXE_CMD_LEN = 4;

    localparam logic [EXE_CMD_LEN-1:0] EXE_NOP = 4'd0;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'd1;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'd2;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND = 4'd3;
    localparam logic [EXE_CMD_LEN-1:0] EXE_OR  = 4'd4;
    localparam logic [EXE_CMD_LEN-1:0] EXE_XOR = 4'd5;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLL = 4'd6;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRL = 4'd7;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_ADDI = 4'd8,
        OP_SLLI = 4'd9,
        OP_SRLI = 4'd10
    } opcode_e;

    typedef struct packed {
        logic [EXE_CMD_LEN-1:0] cmd;
        logic [WORD_LEN-1:0]    a;
        logic [WORD_LEN-1:0]    b;
        logic [REG_IDX_W-1:0]   dst;
    } id_ex_t;

endpackage

// File: rtl/id_issue_stage_reg_file.sv
// 8x16 register file: two combinational read ports with write bypass,
// one synchronous write port (we/waddr/wdata), r0 hardwired to zero.
module reg_file_8x16
    import id_issue_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [WORD_LEN-1:0]  wdata,
    input  logic [REG_IDX_W-1:0] ra1,
    output logic [WORD_LEN-1:0]  rd1,
    input  logic [REG_IDX_W-1:0] ra2,
    output logic [WORD_LEN-1:0]  rd2
);

    logic [WORD_LEN-1:0] mem [NREGS];
    logic                wr;

    assign wr = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rd1 = mem[ra1];
        if (ra1 == '0)                rd1 = '0;
        else if (wr && waddr == ra1) rd1 = wdata;
    end

    always_comb begin
        rd2 = mem[ra2];
        if (ra2 == '0)                rd2 = '0;
        else if (wr && waddr == ra2) rd2 = wdata;
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: valid/ready input, register file, registered ID/EX slot.
// Ports: clk/rst, in_valid/in_ready/instr, flush, out_* slot, wb_*, counters.
module id_issue_stage
    import id_issue_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0]            instr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXE_CMD_LEN-1:0] exe_cmd,
    output logic [WORD_LEN-1:0]    alu_a,
    output logic [WORD_LEN-1:0]    alu_b,
    output logic [REG_IDX_W-1:0]   dst,
    input  logic                   wb_en,
    input  logic [REG_IDX_W-1:0]   wb_addr,
    input  logic [WORD_LEN-1:0]    wb_data,
    output logic [CNT_W-1:0]       issued_cnt,
    output logic [CNT_W-1:0]       illegal_cnt
);

    logic [3:0]           op;
    logic [REG_IDX_W-1:0] rd, rs1, rs2;
    logic [5:0]           imm6;
    logic [WORD_LEN-1:0]  rs1_d, rs2_d;
    logic                 is_rr, is_addi, is_shi, ill;
    logic                 accept;
    id_ex_t               dec, slot;
    logic                 valid_q;

    assign op   = instr[15:12];
    assign rd   = instr[11:9];
    assign rs1  = instr[8:6];
    assign rs2  = instr[5:3];
    assign imm6 = instr[5:0];

    reg_file_8x16 u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_en),
        .waddr (wb_addr),
        .wdata (wb_data),
        .ra1   (rs1),
        .rd1   (rs1_d),
        .ra2   (rs2),
        .rd2   (rs2_d)
    );

    assign is_rr   = (op >= OP_ADD) && (op <= OP_SRL);
    assign is_addi = (op == OP_ADDI);
    assign is_shi  = (op == OP_SLLI) || (op == OP_SRLI);
    assign ill     = (op > OP_SRLI);

    always_comb begin
        dec = '0;
        unique case (1'b1)
            is_rr: begin
                // R-type opcodes share their encoding with exe commands
                dec.cmd = op;
                dec.a   = rs1_d;
                dec.b   = rs2_d;
                dec.dst = rd;
            end
            is_addi: begin
                dec.cmd = EXE_ADD;
                dec.a   = rs1_d;
                dec.b   = {{(WORD_LEN-6){imm6[5]}}, imm6};
                dec.dst = rd;
            end
            is_shi: begin
                dec.cmd = (op == OP_SLLI) ? EXE_SLL : EXE_SRL;
                dec.a   = rs1_d;
                dec.b   = {{(WORD_LEN-4){1'b0}}, imm6[3:0]};
                dec.dst = rd;
            end
            default: dec = '0;
        endcase
    end

    assign in_ready = !rst && !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            slot        <= '0;
            issued_cnt  <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            slot    <= '0;
        end else if (accept) begin
            valid_q    <= 1'b1;
            slot       <= dec;
            issued_cnt <= issued_cnt + 1'b1;
            if (ill) illegal_cnt <= illegal_cnt + 1'b1;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign exe_cmd   = slot.cmd;
    assign alu_a     = slot.a;
    assign alu_b     = slot.b;
    assign dst       = slot.dst;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage with a behavioural reference model.
// Model is compared every negedge; literal checks pin key vectors.
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  exe_cmd;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  dst;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [15:0] issued_cnt;
    logic [15:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    id_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .exe_cmd     (exe_cmd),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .dst         (dst),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .issued_cnt  (issued_cnt),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference model
    logic [15:0] m_reg [8];
    logic        m_valid;
    logic [3:0]  m_cmd;
    logic [15:0] m_a, m_b;
    logic [2:0]  m_dst;
    int          m_iss, m_ill;
    bit          m_live = 0;

    function automatic logic [15:0] rdv(input logic [2:0] r);
        if (r == 0) return 16'h0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_reg[r];
    endfunction

    always @(posedge clk) begin
        int          op;
        logic [15:0] va, vb;
        bit          acc;
        op  = int'(instr[15:12]);
        va  = rdv(instr[8:6]);
        vb  = rdv(instr[5:3]);
        acc = in_valid && !rst && !flush && (!m_valid || out_ready);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
            m_valid = 0; m_cmd = 0; m_a = 0; m_b = 0; m_dst = 0;
            m_iss = 0; m_ill = 0;
            m_live = 1;
        end else begin
            if (flush) begin
                m_valid = 0;
                m_cmd   = 0;
            end else if (acc) begin
                m_valid = 1;
                m_iss   = (m_iss + 1) % 65536;
                m_a = 0; m_b = 0; m_dst = 0; m_cmd = 0;
                if (op >= 1 && op <= 7) begin
                    m_cmd = op[3:0]; m_a = va; m_b = vb;
                    m_dst = instr[11:9];
                end else if (op == 8) begin
                    m_cmd = 1; m_a = va;
                    m_b = 16'(signed'(instr[5:0]));
                    m_dst = instr[11:9];
                end else if (op == 9 || op == 10) begin
                    m_cmd = (op == 9) ? 4'd6 : 4'd7; m_a = va;
                    m_b = 16'(instr[3:0]);
                    m_dst = instr[11:9];
                end else if (op >= 11) begin
                    m_ill = (m_ill + 1) % 65536;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_in_ready", 32'(in_ready),
                32'(!rst && !flush && (!m_valid || out_ready)));
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_issued", 32'(issued_cnt), 32'(m_iss));
            chk("m_illegal", 32'(illegal_cnt), 32'(m_ill));
            if (m_valid) begin
                chk("m_cmd", 32'(exe_cmd), 32'(m_cmd));
                chk("m_a", 32'(alu_a), 32'(m_a));
                chk("m_b", 32'(alu_b), 32'(m_b));
                chk("m_dst", 32'(dst), 32'(m_dst));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 1; instr = 16'h1000; flush = 0;
        out_ready = 1; wb_en = 0; wb_addr = 0; wb_data = 0;
        tick();
        #1 chk("rst_in_ready", 32'(in_ready), 0);
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_cmd", 32'(exe_cmd), 0);
        chk("rst_cnt", 32'(issued_cnt), 0);

        rst = 0;
        tick();
        chk("add_valid", 32'(out_valid), 1);
        chk("add_cmd", 32'(exe_cmd), 1);
        chk("add_ab", {alu_a, alu_b}, 0);
        chk("add_iss", 32'(issued_cnt), 1);

        in_valid = 0;
        wb_en = 1; wb_addr = 1; wb_data = 16'h00FF;
        tick();
        wb_addr = 2; wb_data = 16'h0F0F;
        tick();
        wb_en = 0;
        in_valid = 1; instr = 16'h3650;
        tick();
        chk("and_cmd", 32'(exe_cmd), 3);
        chk("and_a", 32'(alu_a), 32'h00FF);
        chk("and_b", 32'(alu_b), 32'h0F0F);
        chk("and_dst", 32'(dst), 3);

        instr = 16'h1848;
        wb_en = 1; wb_addr = 1; wb_data = 16'h1234;
        tick();
        wb_en = 0;
        chk("byp_ab", {alu_a, alu_b}, 32'h12341234);
        chk("byp_dst", 32'(dst), 4);

        instr = 16'h827F;
        tick();
        chk("addi_a", 32'(alu_a), 32'h1234);
        chk("addi_b", 32'(alu_b), 32'hFFFF);
        instr = 16'h9493;
        tick();
        chk("slli_cmd", 32'(exe_cmd), 6);
        chk("slli_b", 32'(alu_b), 32'h0003);

        out_ready = 0; instr = 16'h2A50;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", 32'(in_ready), 0);
            chk("stall_cmd", 32'(exe_cmd), 6);
            chk("stall_b", 32'(alu_b), 32'h0003);
            chk("stall_iss", 32'(issued_cnt), 5);
        end
        out_ready = 1;
        tick();
        in_valid = 0;
        chk("sub_cmd", 32'(exe_cmd), 2);
        chk("sub_ab", {alu_a, alu_b}, 32'h12340F0F);
        chk("sub_dst", 32'(dst), 5);
        tick();
        chk("sub_once", 32'(issued_cnt), 6);
        chk("drain", 32'(out_valid), 0);

        in_valid = 1; instr = 16'hC6D2;
        tick();
        chk("ill_cmd", 32'(exe_cmd), 0);
        chk("ill_dst", 32'(dst), 0);
        chk("ill_cnt", 32'(illegal_cnt), 1);

        out_ready = 0; instr = 16'h1000; flush = 1;
        wb_en = 1; wb_addr = 6; wb_data = 16'hABCD;
        #1 chk("flush_ready", 32'(in_ready), 0);
        tick();
        flush = 0; wb_en = 0;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_cmd", 32'(exe_cmd), 0);
        out_ready = 1; instr = 16'h1F80;
        tick();
        chk("flush_wb", 32'(alu_a), 32'hABCD);
        chk("flush_iss", 32'(issued_cnt), 8);

        instr = 16'h1000; wb_en = 1; wb_addr = 0; wb_data = 16'h0005;
        tick();
        wb_en = 0;
        chk("r0_zero", {alu_a, alu_b}, 0);

        out_ready = 0; in_valid = 0;
        rst = 1; wb_en = 1; wb_addr = 3; wb_data = 16'h5555;
        tick();
        rst = 0; wb_en = 0;
        chk("rst_stall", 32'(out_valid), 0);
        out_ready = 1; in_valid = 1; instr = 16'h12D8;
        tick();
        in_valid = 0;
        chk("rst_nowb", {alu_a, alu_b}, 0);
        chk("rst_iss", 32'(issued_cnt), 1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode-and-issue stage of the 16-bit three-stage core; the producer side of the execute interface.
- Accepts fetched 16-bit instructions via a valid/ready handshake and decodes them into an execute command plus two operands.
- Holds the 8x16 architectural register file and applies same-cycle writeback bypass.
- Presents the result in a registered ID/EX slot to the combinational execute stage, which writes results back through the wb port.

Parameters:
- WORD_LEN, 16, datapath width; always taken from the shared constant.
- NREGS, 8, register count; r0 reads as zero and ignores writes.
- CNT_W, 16, width of the issued-instruction and illegal-instruction counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers instr.
- in_ready  out  1  stage can accept instr this cycle.
- instr  in  16  [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
- flush  in  1  discard the slot and refuse input this cycle.
- out_valid  out  1  ID/EX slot holds an instruction.
- out_ready  in  1  execute consumes the slot this cycle.
- exe_cmd  out  EXE_CMD_LEN  execute command.
- alu_a  out  16  operand A.
- alu_b  out  16  operand B.
- dst  out  3  destination register.
- wb_en  in  1  writeback strobe from execute.
- wb_addr  in  3  writeback register.
- wb_data  in  16  writeback value.
- issued_cnt  out  CNT_W  instructions accepted.
- illegal_cnt  out  CNT_W  illegal opcodes accepted.

Behaviour:
- Reset (synchronous, active-high):
  - out_valid=0, exe_cmd=EXE_NOP, alu_a=alu_b=0, dst=0.
  - All registers r0..r7 =0; both counters =0.
  - in_ready=0 during the rst cycle.
- Handshake:
  - in_ready = !rst && !flush && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - On accept, the slot loads the decoded instruction at the next edge and out_valid=1.
  - If out_valid && out_ready && !accept, then out_valid<=0.
  - While out_valid && !out_ready, all slot outputs hold stable.
  - Latency: instruction to exe_cmd is 1 cycle.
- Decode:
  - Opcode 0 NOP: exe_cmd=EXE_NOP, dst=0.
  - Opcodes 1-7: ADD, SUB, AND, OR, XOR, SLL, SRL → EXE_ADD..EXE_SRL; alu_a=R[rs1], alu_b=R[rs2].
  - Opcode 8 ADDI: EXE_ADD, alu_b = sign-extended imm6.
  - Opcodes 9 SLLI and 10 SRLI: alu_b = {12'b0, imm6[3:0]}.
  - Opcodes 11-15 are illegal: issued as NOP with dst=0, and illegal_cnt increments.
  - issued_cnt increments on every accept, including NOP and illegal.
  - Both counters wrap modulo 2^CNT_W.
- Register file:
  - Write at the edge when wb_en && wb_addr!=0.
  - Reads of r0 return 0.
  - Bypass: if wb_en && wb_addr==rsX && rsX!=0 in the accept cycle, the operand takes wb_data.
  - Execute writes back in the same cycle it consumes the slot, so back-to-back dependent instructions never stall.
- Flush:
  - Slot invalidated at the next edge: out_valid=0, exe_cmd=EXE_NOP.
  - No accept in a flush cycle.
  - Writeback still occurs in a flush cycle.
- Simultaneous events:
  - Consume + accept in the same cycle: the slot is replaced and out_valid stays 1.
  - flush + out_ready: the slot is dropped.
- rst during a stalled slot: the slot is cleared and the pending wb is ignored.

Decomposition:
- Shared package: WORD_LEN, EXE_CMD_LEN=4, EXE_NOP=0, EXE_ADD=1, EXE_SUB=2, EXE_AND=3, EXE_OR=4, EXE_XOR=5, EXE_SLL=6, EXE_SRL=7, opcode enum, register-index width.
- One sub-module, reg_file_8x16: two combinational read ports with write bypass, one synchronous write port, r0 hardwired to zero.

Test Plan:
- Reset, then in_valid=1, instr=0x1000 (ADD r0,r0,r0), out_ready=1 → next cycle out_valid=1, exe_cmd=1, alu_a=alu_b=0, issued_cnt=1.
- wb r1=0x00FF and r2=0x0F0F in prior cycles, then issue AND r3,r1,r2 (0x3650) → exe_cmd=3, alu_a=0x00FF, alu_b=0x0F0F, dst=3.
- In the accept cycle of ADD r4,r1,r1, also drive wb_en=1, wb_addr=1, wb_data=0x1234 → alu_a=alu_b=0x1234.
- ADDI r1,r1,-1 (imm6=0x3F) → alu_b=0xFFFF; SLLI with imm6=0x13 → alu_b=0x0003.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable; release → the next instruction lands one cycle later with no loss or duplicate.
- Opcode 0xC accepted → exe_cmd=0, dst=0, illegal_cnt=1; flush with a held slot → out_valid=0 next cycle, in_ready=0 during the flush cycle.
